branch_resolver: RTL

- Resolution-and-training end of the branch prediction loop. Sits at the EX stage.
- Compares each resolved conditional branch against the prediction that travelled down the pipe with it, then issues a registered flush/redirect on a mispredict.
- Shifts the global history register and queues a training update.
- Trains the 2-bit counter table with a read-modify-write sequence through a small FIFO, so the predictor's table can stay single-ported.

---
 rtl/branch_resolver_pkg.sv | 17 +
 rtl/br_upd_fifo.sv | 48 ++++
 rtl/branch_resolver.sv | 119 +++++++++++
 3 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: counter states, RMW FSM states, address bus width.
package branch_resolver_pkg;

    localparam int INST_ADDR_BUS_W = 32;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } upd_state_t;

endpackage

// File: rtl/br_upd_fifo.sv
// Pending counter-update queue: synchronous FIFO with combinational head read.
module br_upd_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full queue only lands when a slot frees up the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: registered flush/redirect, global history, and a
// queued read-modify-write trainer for the 2-bit counter table. Optional stats: BR_RESOLVER_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int IDX_W      = 12,
    parameter int HIST_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ex_is_branch,
    input  logic [INST_ADDR_BUS_W-1:0]  ex_pc,
    input  logic                        ex_taken,
    input  logic [INST_ADDR_BUS_W-1:0]  ex_target,
    input  logic                        ex_pdt_res,
    output logic                        flush,
    output logic [INST_ADDR_BUS_W-1:0]  redirect_pc,
    output logic [HIST_W-1:0]           ghr,
    output logic                        stallreq,
    output logic                        tbl_re,
    output logic                        tbl_we,
    output logic [IDX_W-1:0]            tbl_addr,
    output logic [1:0]                  tbl_wdata,
    input  logic [1:0]                  tbl_rdata
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [31:0]                 stat_branches,
    output logic [31:0]                 stat_mispredicts,
    output logic [15:0]                 stat_drops
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [1:0] sat(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == STRONG_T)  ? STRONG_T  : ctr + 2'd1;
        else       return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
    endfunction

    upd_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   head;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             fifo_pop;
    logic             upd_taken;

    assign idx      = ex_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign fifo_pop = (state == ST_IDLE) && !empty;
    assign stallreq = (count == CNT_W'(FIFO_DEPTH));

    br_upd_fifo #(.W(IDX_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ex_is_branch),
        .pop   (fifo_pop),
        .din   ({idx, ex_taken}),
        .dout  (head),
        .full  (),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            ghr         <= '0;
            tbl_re      <= 1'b0;
            tbl_we      <= 1'b0;
            tbl_addr    <= '0;
            tbl_wdata   <= '0;
            upd_taken   <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            if (ex_is_branch) begin
                flush       <= (ex_taken != ex_pdt_res);
                redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
                ghr         <= {ghr[HIST_W-2:0], ex_taken};
            end else begin
                flush <= 1'b0;
            end

            tbl_re <= 1'b0;
            tbl_we <= 1'b0;
            case (state)
                ST_IDLE: if (!empty) begin
                    tbl_re    <= 1'b1;
                    tbl_addr  <= head[IDX_W:1];
                    upd_taken <= head[0];
                    state     <= ST_READ;
                end
                ST_READ:  state <= ST_WRITE;
                // The table answers the cycle after it sees tbl_re, which is this state.
                ST_WRITE: begin
                    tbl_we    <= 1'b1;
                    tbl_wdata <= sat(tbl_rdata, upd_taken);
                    state     <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef BR_RESOLVER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            stat_drops       <= '0;
        end else if (ex_is_branch) begin
            stat_branches <= stat_branches + 32'd1;
            if (ex_taken != ex_pdt_res) stat_mispredicts <= stat_mispredicts + 32'd1;
            if (stallreq && !fifo_pop && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule
